// File: rtl/rs_simple.sv
// rs_simple: age-ordered reservation station for the simple integer unit.
// Ports: clk/rst, flush, dispatch (disp_*), CDB wakeup (cdb_*), two issue
// slots (rs_simple_0/1, entry numbers, selector), issue strobes, count.
// Optional macro RS_SIMPLE_DISP_BYPASS_EN: dispatched operands also
// capture a same-cycle CDB broadcast.
module rs_simple #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [80:0]      disp_inst,
    input  logic [ROB_W-1:0] disp_rob_num,
    output logic             disp_ready,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_num,
    input  logic [31:0]      cdb_data,
    output logic [80:0]      rs_simple_0,
    output logic [80:0]      rs_simple_1,
    output logic [ROB_W-1:0] rs_simple_0_entry_num,
    output logic [ROB_W-1:0] rs_simple_1_entry_num,
    output logic             selector,
    input  logic             simple_0_issue,
    input  logic             simple_1_issue,
    output logic [3:0]       count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [80:0]      inst_q [DEPTH];
    logic [ROB_W-1:0] rob_q  [DEPTH];
    logic [DEPTH-1:0] occ_q;
    logic [3:0]       count_q;

    logic [80:0]      inst_n [DEPTH];
    logic [ROB_W-1:0] rob_n  [DEPTH];
    logic [DEPTH-1:0] occ_n;
    logic [3:0]       count_n;

    logic          sel0_v, sel1_v;
    logic [IW-1:0] sel0_idx, sel1_idx;

    // Load a CDB result into any still-pending source whose tag matches.
    function automatic logic [80:0] wake(
        input logic [80:0]      e,
        input logic             v,
        input logic [ROB_W-1:0] t,
        input logic [31:0]      d
    );
        logic [80:0] r;
        r = e;
        if (v && !e[5] && e[6 +: ROB_W] == t) begin
            r[37:6] = d;
            r[5]    = 1'b1;
        end
        if (v && !e[38] && e[39 +: ROB_W] == t) begin
            r[70:39] = d;
            r[38]    = 1'b1;
        end
        return r;
    endfunction

    // Priority scan from the oldest entry for the first two ready ones.
    always_comb begin
        sel0_v   = 1'b0;
        sel1_v   = 1'b0;
        sel0_idx = '0;
        sel1_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_q[IW'(i)] && inst_q[IW'(i)][5] && inst_q[IW'(i)][38]) begin
                if (!sel0_v) begin
                    sel0_v   = 1'b1;
                    sel0_idx = IW'(i);
                end else if (!sel1_v) begin
                    sel1_v   = 1'b1;
                    sel1_idx = IW'(i);
                end
            end
        end
    end

    assign rs_simple_0 = sel0_v ? inst_q[sel0_idx] : '0;
    assign rs_simple_1 = sel1_v ? inst_q[sel1_idx] : '0;
    assign rs_simple_0_entry_num = sel0_v ? rob_q[sel0_idx] : '0;
    assign rs_simple_1_entry_num = sel1_v ? rob_q[sel1_idx] : '0;
    assign selector   = sel1_v;
    assign disp_ready = int'(count_q) < DEPTH;
    assign count      = count_q;

    // Drop issued entries, wake and compact survivors, then append.
    always_comb begin
        int          k;
        logic        rm;
        logic [80:0] d;
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            inst_n[IW'(i)] = '0;
            rob_n[IW'(i)]  = '0;
            occ_n[IW'(i)]  = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            rm = (sel0_v && simple_0_issue && sel0_idx == IW'(i)) ||
                 (sel1_v && simple_1_issue && sel1_idx == IW'(i));
            if (occ_q[IW'(i)] && !rm) begin
                inst_n[IW'(k)] = wake(inst_q[IW'(i)], cdb_valid,
                                      cdb_rob_num, cdb_data);
                rob_n[IW'(k)]  = rob_q[IW'(i)];
                occ_n[IW'(k)]  = 1'b1;
                k = k + 1;
            end
        end
`ifdef RS_SIMPLE_DISP_BYPASS_EN
        d = wake(disp_inst, cdb_valid, cdb_rob_num, cdb_data);
`else
        d = disp_inst;
`endif
        if (disp_valid && disp_ready && k < DEPTH) begin
            inst_n[IW'(k)] = d;
            rob_n[IW'(k)]  = disp_rob_num;
            occ_n[IW'(k)]  = 1'b1;
            k = k + 1;
        end
        count_n = 4'(k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[IW'(i)] <= '0;
                rob_q[IW'(i)]  <= '0;
            end
        end else if (flush) begin
            occ_q   <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_n;
            count_q <= count_n;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[IW'(i)] <= inst_n[IW'(i)];
                rob_q[IW'(i)]  <= rob_n[IW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_rs_simple.sv
// tb_rs_simple: directed self-checking bench for rs_simple.
// Drives inputs 1 time unit after each rising edge and checks outputs there.
module tb_rs_simple;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic [80:0] disp_inst;
    logic [3:0]  disp_rob_num;
    logic        disp_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_num;
    logic [31:0] cdb_data;
    logic [80:0] rs_simple_0;
    logic [80:0] rs_simple_1;
    logic [3:0]  rs_simple_0_entry_num;
    logic [3:0]  rs_simple_1_entry_num;
    logic        selector;
    logic        simple_0_issue;
    logic        simple_1_issue;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rs_simple dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .disp_valid(disp_valid),
        .disp_inst(disp_inst),
        .disp_rob_num(disp_rob_num),
        .disp_ready(disp_ready),
        .cdb_valid(cdb_valid),
        .cdb_rob_num(cdb_rob_num),
        .cdb_data(cdb_data),
        .rs_simple_0(rs_simple_0),
        .rs_simple_1(rs_simple_1),
        .rs_simple_0_entry_num(rs_simple_0_entry_num),
        .rs_simple_1_entry_num(rs_simple_1_entry_num),
        .selector(selector),
        .simple_0_issue(simple_0_issue),
        .simple_1_issue(simple_1_issue),
        .count(count)
    );

    function automatic logic [80:0] mk(
        input logic [4:0]  rd,
        input logic [31:0] s1,
        input logic        s1v,
        input logic [31:0] s2,
        input logic        s2v
    );
        return {5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s2, s2v, s1, s1v, rd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush          = 1'b0;
        disp_valid     = 1'b0;
        disp_inst      = '0;
        disp_rob_num   = '0;
        cdb_valid      = 1'b0;
        cdb_rob_num    = '0;
        cdb_data       = '0;
        simple_0_issue = 1'b0;
        simple_1_issue = 1'b0;
    endtask

    task automatic disp(input logic [80:0] e, input logic [3:0] r);
        disp_valid   = 1'b1;
        disp_inst    = e;
        disp_rob_num = r;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++;
            $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (disp_ready !== 1'b1) begin bad++;
            $display("FAIL reset_ready got=%b want=1", disp_ready); end
        total++; if (rs_simple_0 !== 81'd0 || rs_simple_1 !== 81'd0) begin bad++;
            $display("FAIL reset_slots got=%h/%h want=0", rs_simple_0, rs_simple_1); end
        total++; if (selector !== 1'b0 || rs_simple_0_entry_num !== 4'd0 ||
                     rs_simple_1_entry_num !== 4'd0) begin bad++;
            $display("FAIL reset_sel got=%b/%0d/%0d want=0", selector,
                     rs_simple_0_entry_num, rs_simple_1_entry_num); end
    endtask

    task automatic test_dispatch();
        logic [80:0] e;
        e = mk(5'd1, 32'd5, 1'b1, 32'd7, 1'b1);
        disp(e, 4'd3);
        total++; if (rs_simple_0 !== e) begin bad++;
            $display("FAIL disp_slot0 got=%h want=%h", rs_simple_0, e); end
        total++; if (rs_simple_0_entry_num !== 4'd3) begin bad++;
            $display("FAIL disp_en0 got=%0d want=3", rs_simple_0_entry_num); end
        total++; if (rs_simple_1 !== 81'd0 || selector !== 1'b0) begin bad++;
            $display("FAIL disp_slot1 got=%h/%b want=0/0", rs_simple_1, selector); end
        total++; if (count !== 4'd1) begin bad++;
            $display("FAIL disp_count got=%0d want=1", count); end
        simple_0_issue = 1'b1;
        step();
        idle();
        total++; if (count !== 4'd0 || rs_simple_0 !== 81'd0) begin bad++;
            $display("FAIL disp_issue got=%0d/%h want=0/0", count, rs_simple_0); end
    endtask

    task automatic test_wakeup();
        logic [80:0] a, aw, b;
        a  = mk(5'd2, 32'd6, 1'b0, 32'd1, 1'b1);
        aw = mk(5'd2, 32'h1234, 1'b1, 32'd1, 1'b1);
        b  = mk(5'd3, 32'd8, 1'b1, 32'd9, 1'b1);
        disp(a, 4'd1);
        disp(b, 4'd2);
        total++; if (rs_simple_0 !== b || rs_simple_0_entry_num !== 4'd2) begin bad++;
            $display("FAIL wk_pre_slot0 got=%h/%0d want=%h/2", rs_simple_0,
                     rs_simple_0_entry_num, b); end
        total++; if (rs_simple_1 !== 81'd0 || selector !== 1'b0 || count !== 4'd2) begin bad++;
            $display("FAIL wk_pre_slot1 got=%h/%b/%0d want=0/0/2", rs_simple_1,
                     selector, count); end
        cdb_valid   = 1'b1;
        cdb_rob_num = 4'd6;
        cdb_data    = 32'h1234;
        step();
        idle();
        total++; if (rs_simple_0 !== aw || rs_simple_0_entry_num !== 4'd1) begin bad++;
            $display("FAIL wk_slot0 got=%h/%0d want=%h/1", rs_simple_0,
                     rs_simple_0_entry_num, aw); end
        total++; if (rs_simple_1 !== b || rs_simple_1_entry_num !== 4'd2) begin bad++;
            $display("FAIL wk_slot1 got=%h/%0d want=%h/2", rs_simple_1,
                     rs_simple_1_entry_num, b); end
        total++; if (selector !== 1'b1) begin bad++;
            $display("FAIL wk_sel got=%b want=1", selector); end
        simple_0_issue = 1'b1;
        simple_1_issue = 1'b1;
        step();
        idle();
        total++; if (count !== 4'd0) begin bad++;
            $display("FAIL wk_clear got=%0d want=0", count); end
    endtask

    task automatic test_full();
        logic [80:0] e;
        for (int i = 4; i < 8; i++) begin
            e = mk(5'(i), 32'(i), 1'b1, 32'(i + 10), 1'b1);
            disp(e, 4'(i));
        end
        total++; if (count !== 4'd4 || disp_ready !== 1'b0) begin bad++;
            $display("FAIL full_state got=%0d/%b want=4/0", count, disp_ready); end
        disp(mk(5'd8, 32'd8, 1'b1, 32'd8, 1'b1), 4'd8);
        total++; if (count !== 4'd4 || rs_simple_0_entry_num !== 4'd4 ||
                     rs_simple_1_entry_num !== 4'd5) begin bad++;
            $display("FAIL full_drop got=%0d/%0d/%0d want=4/4/5", count,
                     rs_simple_0_entry_num, rs_simple_1_entry_num); end
        simple_0_issue = 1'b1;
        disp_valid     = 1'b1;
        disp_inst      = mk(5'd9, 32'd9, 1'b1, 32'd9, 1'b1);
        disp_rob_num   = 4'd9;
        step();
        idle();
        total++; if (count !== 4'd3 || disp_ready !== 1'b1) begin bad++;
            $display("FAIL full_issue got=%0d/%b want=3/1", count, disp_ready); end
        total++; if (rs_simple_0_entry_num !== 4'd5 || rs_simple_1_entry_num !== 4'd6) begin bad++;
            $display("FAIL full_shift got=%0d/%0d want=5/6", rs_simple_0_entry_num,
                     rs_simple_1_entry_num); end
    endtask

    task automatic test_back_to_back();
        logic [80:0] e7, e10;
        e7  = mk(5'd7, 32'd7, 1'b1, 32'd17, 1'b1);
        e10 = mk(5'd10, 32'd10, 1'b1, 32'd20, 1'b1);
        simple_0_issue = 1'b1;
        simple_1_issue = 1'b1;
        disp_valid     = 1'b1;
        disp_inst      = e10;
        disp_rob_num   = 4'd10;
        step();
        idle();
        total++; if (count !== 4'd2) begin bad++;
            $display("FAIL b2b_count got=%0d want=2", count); end
        total++; if (rs_simple_0 !== e7 || rs_simple_0_entry_num !== 4'd7) begin bad++;
            $display("FAIL b2b_slot0 got=%h/%0d want=%h/7", rs_simple_0,
                     rs_simple_0_entry_num, e7); end
        total++; if (rs_simple_1 !== e10 || rs_simple_1_entry_num !== 4'd10) begin bad++;
            $display("FAIL b2b_slot1 got=%h/%0d want=%h/10", rs_simple_1,
                     rs_simple_1_entry_num, e10); end
        disp(mk(5'd11, 32'd1, 1'b1, 32'd2, 1'b1), 4'd11);
        total++; if (count !== 4'd3) begin bad++;
            $display("FAIL b2b_refill got=%0d want=3", count); end
    endtask

    task automatic test_flush();
        flush        = 1'b1;
        disp_valid   = 1'b1;
        disp_inst    = mk(5'd12, 32'd1, 1'b1, 32'd1, 1'b1);
        disp_rob_num = 4'd12;
        cdb_valid    = 1'b1;
        cdb_rob_num  = 4'd6;
        cdb_data     = 32'h55;
        step();
        idle();
        total++; if (count !== 4'd0 || disp_ready !== 1'b1) begin bad++;
            $display("FAIL flush_count got=%0d/%b want=0/1", count, disp_ready); end
        total++; if (rs_simple_0 !== 81'd0 || rs_simple_1 !== 81'd0 || selector !== 1'b0 ||
                     rs_simple_0_entry_num !== 4'd0) begin bad++;
            $display("FAIL flush_slots got=%h/%h/%b want=0", rs_simple_0,
                     rs_simple_1, selector); end
        disp(mk(5'd1, 32'd1, 1'b1, 32'd1, 1'b1), 4'd1);
        disp(mk(5'd2, 32'd2, 1'b1, 32'd2, 1'b1), 4'd2);
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 4'd0 || rs_simple_0 !== 81'd0 || rs_simple_1 !== 81'd0 ||
                     selector !== 1'b0) begin bad++;
            $display("FAIL async_rst got=%0d/%h/%h want=0", count, rs_simple_0,
                     rs_simple_1); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        logic [80:0] e, ew;
        e  = mk(5'd4, 32'd3, 1'b1, 32'd9, 1'b0);
        ew = mk(5'd4, 32'd3, 1'b1, 32'hAA, 1'b1);
        cdb_valid   = 1'b1;
        cdb_rob_num = 4'd9;
        cdb_data    = 32'hAA;
        disp(e, 4'd12);
        total++; if (count !== 4'd1) begin bad++;
            $display("FAIL byp_count got=%0d want=1", count); end
`ifdef RS_SIMPLE_DISP_BYPASS_EN
        total++; if (rs_simple_0 !== ew || rs_simple_0_entry_num !== 4'd12) begin bad++;
            $display("FAIL byp_on got=%h want=%h", rs_simple_0, ew); end
`else
        total++; if (rs_simple_0 !== 81'd0) begin bad++;
            $display("FAIL byp_off got=%h want=0", rs_simple_0); end
        cdb_valid   = 1'b1;
        cdb_rob_num = 4'd9;
        cdb_data    = 32'hAA;
        step();
        idle();
        total++; if (rs_simple_0 !== ew || rs_simple_0_entry_num !== 4'd12) begin bad++;
            $display("FAIL byp_late got=%h want=%h", rs_simple_0, ew); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_dispatch();
        test_wakeup();
        test_full();
        test_back_to_back();
        test_flush();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
